// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and default widths for mem_arbiter.
package mem_arb_pkg;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CPU_ISSUE = 3'd1;
  localparam logic [2:0] ST_CPU_DONE  = 3'd2;
  localparam logic [2:0] ST_DMA_ISSUE = 3'd3;
  localparam logic [2:0] ST_DMA_DONE  = 3'd4;
  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    CPU_ISSUE = ST_CPU_ISSUE,
    CPU_DONE  = ST_CPU_DONE,
    DMA_ISSUE = ST_DMA_ISSUE,
    DMA_DONE  = ST_DMA_DONE
  } state_e;
  typedef enum logic {GNT_CPU, GNT_DMA} grant_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, DMA and memory buses of mem_arbiter; dma_lock exists only with MEM_ARB_LOCK_EN.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          cpu_req, cpu_we, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ready;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic          dma_lock;
`endif
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  dma_lock,
`endif
    input  mem_rdata,
    output cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    output mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
`ifdef MEM_ARB_LOCK_EN
    output dma_lock,
`endif
    output mem_rdata,
    input  cpu_ready, cpu_rdata, dma_ready, dma_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational two-way round-robin pick with a DMA lock override.
module mem_arb_rr import mem_arb_pkg::*; (
  input  logic   cpu_req,
  input  logic   dma_req,
  input  grant_e last_grant,
  input  logic   lock,
  output grant_e gnt
);
  always_comb gnt = (dma_req && (lock || !cpu_req || last_grant == GNT_CPU)) ? GNT_DMA : GNT_CPU;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between CPU and DMA, 3 cycles per access.
// Defining MEM_ARB_LOCK_EN adds dma_lock bursts of up to MAX_BURST consecutive DMA accesses.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef MEM_ARB_LOCK_EN
  , parameter int MAX_BURST = 8
`endif
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);
  state_e        state, state_nx;
  grant_e        last_grant, gnt;
  logic          lock, cpu_sel, dma_sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
`ifdef MEM_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst;
  always_comb lock = burst != '0 && burst < BW'(MAX_BURST);
  // Saturates at MAX_BURST so a lone locked DMA can keep going without wrapping.
  always_ff @(posedge clk or posedge reset)
    if (reset) burst <= '0;
    else if (state == IDLE && state_nx == CPU_ISSUE) burst <= '0;
    else if (state == IDLE && state_nx == DMA_ISSUE && burst != BW'(MAX_BURST)) burst <= burst + 1'b1;
    else if (state == DMA_DONE && !bus.dma_lock) burst <= '0;
`else
  always_comb lock = 1'b0;
`endif
  mem_arb_rr u_rr (
    .cpu_req   (bus.cpu_req),
    .dma_req   (bus.dma_req),
    .last_grant(last_grant),
    .lock      (lock),
    .gnt       (gnt)
  );
  always_comb begin
    case (state)
      IDLE:      state_nx = !(bus.cpu_req || bus.dma_req) ? IDLE : gnt == GNT_CPU ? CPU_ISSUE : DMA_ISSUE;
      CPU_ISSUE: state_nx = CPU_DONE;
      DMA_ISSUE: state_nx = DMA_DONE;
      default:   state_nx = IDLE;
    endcase
  end
  // Payload stays selected through DONE; requesters hold it until ready.
  always_comb begin
    cpu_sel       = state == CPU_ISSUE || state == CPU_DONE;
    dma_sel       = state == DMA_ISSUE || state == DMA_DONE;
    addr          = cpu_sel ? bus.cpu_addr : dma_sel ? bus.dma_addr : '0;
    wdata         = cpu_sel ? bus.cpu_wdata : dma_sel ? bus.dma_wdata : '0;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_we    = state == CPU_ISSUE ? bus.cpu_we : state == DMA_ISSUE ? bus.dma_we : 1'b0;
    bus.cpu_ready = state == CPU_DONE;
    bus.dma_ready = state == DMA_DONE;
    bus.cpu_rdata = state == CPU_DONE && !bus.cpu_we ? bus.mem_rdata : '0;
    bus.dma_rdata = state == DMA_DONE && !bus.dma_we ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_DMA;
    end else begin
      state <= state_nx;
      if (state == CPU_ISSUE) last_grant <= GNT_CPU;
      else if (state == DMA_ISSUE) last_grant <= GNT_DMA;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
`ifdef MEM_ARB_LOCK_EN
  mem_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
`else
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    if (bus.mem_we) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
  end
  // Model: one access record in flight; ph = -1 idle, 0 issue cycle, 1 ready cycle.
  int          ph, lock_run, n_vec, n_err;
  logic        own, last, a_we, rnd, keep;
  logic [31:0] a_addr, a_wdata;
  logic [7:0]  seq;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic lock_on();
`ifdef MEM_ARB_LOCK_EN
    return bus.dma_lock;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] rand_addr();
    return 32'(16 + $urandom_range(0, 15)) << 2;
  endfunction
  task automatic model_reset();
    ph = -1;
    last = 1'b1;
    lock_run = 0;
    own = 1'b0;
    a_we = 1'b0;
    a_addr = '0;
    a_wdata = '0;
  endtask
  task automatic new_cpu();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'($urandom_range(0, 1));
    bus.cpu_addr = rand_addr();
    bus.cpu_wdata = $urandom;
  endtask
  task automatic new_dma();
    bus.dma_req = 1'b1;
    bus.dma_we = 1'($urandom_range(0, 1));
    bus.dma_addr = rand_addr();
    bus.dma_wdata = $urandom;
  endtask
  task automatic check_outputs();
    logic cr, dr;
    logic [31:0] rd;
    cr = ph == 1 && !own;
    dr = ph == 1 && own;
    rd = a_we ? 32'h0 : ref_mem[a_addr[7:2]];
    chk("mem_we", 32'(bus.mem_we), 32'(ph == 0 && a_we));
    chk("mem_addr", bus.mem_addr, ph >= 0 ? a_addr : 32'h0);
    if (ph != 1) chk("mem_wdata", bus.mem_wdata, ph == 0 ? a_wdata : 32'h0);
    chk("cpu_ready", 32'(bus.cpu_ready), 32'(cr));
    chk("dma_ready", 32'(bus.dma_ready), 32'(dr));
    chk("cpu_rdata", bus.cpu_rdata, cr ? rd : 32'h0);
    chk("dma_rdata", bus.dma_rdata, dr ? rd : 32'h0);
    if (bus.cpu_ready || bus.dma_ready) seq = {seq[6:0], bus.dma_ready};
  endtask
  // Advance the model across the next clock edge using the inputs now applied.
  task automatic update();
    logic ovr;
    if (ph == 0) begin
      if (a_we) ref_mem[a_addr[7:2]] = a_wdata;
      ph = 1;
    end else if (ph == 1) begin
      if (own) lock_run = lock_on() ? lock_run + 1 : 0;
      ph = -1;
    end else if (bus.cpu_req || bus.dma_req) begin
      ovr = lock_run > 0 && lock_run < MB && bus.dma_req;
      own = ovr ? 1'b1 : !bus.cpu_req ? 1'b1 : !bus.dma_req ? 1'b0 : !last;
      if (!own) lock_run = 0;
      last = own;
      a_we = own ? bus.dma_we : bus.cpu_we;
      a_addr = own ? bus.dma_addr : bus.cpu_addr;
      a_wdata = own ? bus.dma_wdata : bus.cpu_wdata;
      ph = 0;
    end
  endtask
  task automatic drive();
    if (ph == 1 && !own) begin
      if (keep || (rnd && $urandom_range(0, 1) == 1)) new_cpu(); else bus.cpu_req = 1'b0;
    end else if (rnd && !bus.cpu_req && $urandom_range(0, 2) == 0) new_cpu();
    if (ph == 1 && own) begin
      if (keep || (rnd && $urandom_range(0, 1) == 1)) new_dma(); else bus.dma_req = 1'b0;
    end else if (rnd && !bus.dma_req && $urandom_range(0, 2) == 0) new_dma();
`ifdef MEM_ARB_LOCK_EN
    if (rnd) bus.dma_lock = $urandom_range(0, 3) != 0;
`endif
  endtask
  task automatic cycle();
    update();
    @(negedge clk);
    check_outputs();
    drive();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_outputs();
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1234_5638 + 32'(i) * 4;
      ref_mem[i] = 32'h1234_5638 + 32'(i) * 4;
    end
    n_vec = 0;
    n_err = 0;
    rnd = 1'b0;
    keep = 1'b0;
    seq = '0;
    {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} = '0;
    {bus.dma_req, bus.dma_we, bus.dma_addr, bus.dma_wdata} = '0;
`ifdef MEM_ARB_LOCK_EN
    bus.dma_lock = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h40;
    cycle();
    chk("rd_issue_addr", bus.mem_addr, 32'h40);
    cycle();
    chk("rd_0x40", bus.cpu_rdata, 32'h1234_5678);
    cycle();
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 32'h80;
    bus.dma_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("wr_we_issue", 32'(bus.mem_we), 32'h1);
    cycle();
    chk("wr_we_done", 32'(bus.mem_we), 32'h0);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h80;
    repeat (3) cycle();
    chk("raw_0x80", bus.cpu_rdata, 32'hDEAD_BEEF);
    do_reset();
    keep = 1'b1;
    new_cpu();
    new_dma();
    seq = '0;
    repeat (24) cycle();
    keep = 1'b0;
    chk("alt_order", 32'(seq), 32'h55);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    do_reset();
    bus.dma_lock = 1'b1;
    keep = 1'b1;
    new_cpu();
    new_dma();
    seq = '0;
    repeat (18) cycle();
    keep = 1'b0;
    chk("lock_order", 32'(seq), 32'h1E);
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    bus.dma_lock = 1'b0;
`endif
    do_reset();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 32'h44;
    bus.cpu_wdata = 32'hA5A5_5A5A;
    cycle();
    chk("rst_pre_we", 32'(bus.mem_we), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_we", 32'(bus.mem_we), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    cycle();
    cycle();
    chk("rst_retry_ready", 32'(bus.cpu_ready), 32'h1);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h44;
    repeat (3) cycle();
    chk("rst_retry_data", bus.cpu_rdata, 32'hA5A5_5A5A);
    cycle();
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h48;
    keep = 1'b1;
    cycle();
    cycle();
    keep = 1'b0;
    cycle();
    chk("no_dup_ready", 32'(bus.cpu_ready), 32'h0);
    cycle();
    cycle();
    chk("held_req_ready", 32'(bus.cpu_ready), 32'h1);
    rnd = 1'b1;
    repeat (3000) cycle();
    rnd = 1'b0;
    repeat (3) cycle();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    repeat (4) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory port between the multicycle CPU (instruction fetch plus load/store) and a DMA/IO requester. Each requester issues one access at a time over a req/ready handshake. A small FSM sequences every access through issue and complete phases. Round-robin arbitration resolves simultaneous requests.

## Interface
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- MAX_BURST, 8, maximum consecutive locked DMA grants (only used when MEM_ARB_LOCK_EN is defined)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request; held with payload until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; valid only while cpu_ready=1, else 0
- dma_req, dma_we, dma_addr, dma_wdata, dma_ready, dma_rdata: same meaning for the DMA side
- dma_lock  in  1  hold the grant for the next DMA access (present only with MEM_ARB_LOCK_EN)
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous-read data, valid the cycle after the address is presented

## Operation
- States: IDLE, CPU_ISSUE, CPU_DONE, DMA_ISSUE, DMA_DONE. Reset state is IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, only cpu_req: go to CPU_ISSUE. Only dma_req: go to DMA_ISSUE.
- IDLE, both requests: grant the requester not recorded in last_grant. last_grant resets to DMA, so the CPU wins the first tie.
- X_ISSUE:
  - mem_addr and mem_wdata come from requester X.
  - mem_we = X_we.
  - last_grant <= X.
  - Unconditionally go to X_DONE.
- X_DONE:
  - X_ready = 1.
  - X_rdata = mem_rdata for reads, 0 for writes.
  - mem_we = 0; mem_addr still held.
  - Go to IDLE.
  - Requests are ignored in this state.
- Requesters must drop req, or present a new payload, in the cycle after ready. A req still high in IDLE is treated as a new access.
- In IDLE: mem_we=0, mem_addr=0, mem_wdata=0.
- No access is ever split, reordered or preempted once in ISSUE.

## Timing
- Every access takes exactly 3 cycles: IDLE→ISSUE→DONE, then back to IDLE.
- Latency from req sampled in IDLE to ready is 2 cycles.
- Peak throughput is 1 access per 3 cycles.
- The write takes effect at the clock edge ending ISSUE.
- Reset values: all ready=0, all rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, last_grant=DMA, burst counter=0.
- Reset mid-access: asynchronous return to IDLE and mem_we drops immediately. A write whose ISSUE edge coincides with reset assertion is not guaranteed to complete. No ready is produced for the aborted access.
- Under continuous requests from both sides, grants strictly alternate CPU, DMA, CPU, and so on. Worst-case wait is 6 cycles.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - The dma_lock port exists.
  - If dma_lock=1 in DMA_DONE, the next IDLE grants DMA even when the CPU is also requesting.
  - A counter limits locked grants to MAX_BURST consecutive DMA accesses. After the limit, a pending cpu_req wins and the counter clears.
  - The counter also clears on any CPU grant or on dma_lock=0.
- MEM_ARB_LOCK_EN undefined:
  - No dma_lock port and no counter.
  - Pure round-robin.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (5 states, 3-bit encoding);
  - the grant enum {GNT_CPU, GNT_DMA};
  - default AW/DW constants.
- Sub-module mem_arb_rr: combinational 2-way round-robin pick from (cpu_req, dma_req, last_grant, lock override). It outputs the grant enum.
- The FSM, payload mux, and last_grant and burst registers stay in mem_arbiter.

## Test plan
- Lone CPU read at 0x40 (memory holds 0x1234_5678) → mem_addr=0x40 in ISSUE; cpu_ready one cycle later with cpu_rdata=0x1234_5678; dma_ready stays 0.
- DMA write 0xDEAD_BEEF to 0x80, then CPU read of 0x80 → mem_we high for exactly one cycle; the CPU read returns 0xDEAD_BEEF.
- Both requesting from reset for 4 accesses each → grant order CPU, DMA, CPU, DMA, and so on; each ready is 3 cycles apart on alternating sides.
- Reset asserted during CPU_ISSUE of a write → mem_we=0 immediately; no cpu_ready; FSM in IDLE; after release the pending req is served normally.
- With MEM_ARB_LOCK_EN, MAX_BURST=4, dma_lock=1 and cpu_req held → 4 consecutive DMA grants, then a CPU grant.
- Without the macro, the same stimulus minus dma_lock → alternating grants.
- cpu_req kept high through DONE with a new address → the second access is served from the next IDLE, with no duplicate ready.
